// File: rtl/quad_lane_router.sv
// Routes a raster pixel stream to four lanes by (row parity, column parity) through a
// single output register. Optional error flags under QUAD_LANE_ROUTER_ERR_EN.
module quad_lane_router #(
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    input  logic               up_tlast,
    input  logic               up_tuser,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data_a,
    output logic               down_valid_a,
    output logic               down_tlast_a,
    output logic               down_tuser_a,
    input  logic               down_ready_a,
    output logic [D_WIDTH-1:0] down_data_b,
    output logic               down_valid_b,
    output logic               down_tlast_b,
    output logic               down_tuser_b,
    input  logic               down_ready_b,
    output logic [D_WIDTH-1:0] down_data_c,
    output logic               down_valid_c,
    output logic               down_tlast_c,
    output logic               down_tuser_c,
    input  logic               down_ready_c,
    output logic [D_WIDTH-1:0] down_data_d,
    output logic               down_valid_d,
    output logic               down_tlast_d,
    output logic               down_tuser_d,
    input  logic               down_ready_d
`ifdef QUAD_LANE_ROUTER_ERR_EN
    ,
    output logic               err_odd_width,
    output logic               err_odd_height
`endif
);

    typedef enum logic {SYNC, RUN} state_t;

    state_t             state, state_nxt;
    logic               row, row_nxt, col, col_nxt;
    logic               full, full_nxt;
    logic [1:0]         sel, sel_nxt;
    logic [D_WIDTH-1:0] data_q;
    logic               last_q, user_q;
    logic               load, accept;
    logic [3:0]         lane_ready, lane_valid;

    assign lane_ready = {down_ready_d, down_ready_c, down_ready_b, down_ready_a};
    assign up_ready   = !full || lane_ready[sel];
    assign accept     = up_valid && up_ready;

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        sel_nxt   = sel;
        full_nxt  = full;
        load      = 1'b0;
        case (state)
            SYNC: if (accept && up_tuser) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN:  load = accept;
            default: state_nxt = SYNC;
        endcase
        if (load) begin
            full_nxt = 1'b1;
            sel_nxt  = up_tuser ? 2'b00 : {row, col};
            // A start-of-frame beat occupies (0,0); the counters then point past it.
            if (up_tuser) begin
                row_nxt = up_tlast;
                col_nxt = !up_tlast;
            end else if (up_tlast) begin
                row_nxt = !row;
                col_nxt = 1'b0;
            end else begin
                col_nxt = !col;
            end
        end else if (full && lane_ready[sel]) begin
            full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= SYNC;
            row    <= 1'b0;
            col    <= 1'b0;
            sel    <= 2'b00;
            full   <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            user_q <= 1'b0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            sel   <= sel_nxt;
            full  <= full_nxt;
            if (load) begin
                data_q <= up_data;
                last_q <= up_tlast;
                user_q <= up_tuser;
            end
        end
    end

    // Non-selected lanes see zeros so payload only appears where valid is raised.
    always_comb begin
        for (int i = 0; i < 4; i++) lane_valid[i] = full && (sel == i[1:0]);
    end

    assign down_valid_a = lane_valid[0];
    assign down_valid_b = lane_valid[1];
    assign down_valid_c = lane_valid[2];
    assign down_valid_d = lane_valid[3];
    assign down_data_a  = lane_valid[0] ? data_q : '0;
    assign down_data_b  = lane_valid[1] ? data_q : '0;
    assign down_data_c  = lane_valid[2] ? data_q : '0;
    assign down_data_d  = lane_valid[3] ? data_q : '0;
    assign down_tlast_a = lane_valid[0] && last_q;
    assign down_tlast_b = lane_valid[1] && last_q;
    assign down_tlast_c = lane_valid[2] && last_q;
    assign down_tlast_d = lane_valid[3] && last_q;
    assign down_tuser_a = lane_valid[0] && user_q;
    assign down_tuser_b = lane_valid[1] && user_q;
    assign down_tuser_c = lane_valid[2] && user_q;
    assign down_tuser_d = lane_valid[3] && user_q;

`ifdef QUAD_LANE_ROUTER_ERR_EN
    // A tuser beat always sits in column 0, so it counts as col = 0 for width checks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_odd_width  <= 1'b0;
            err_odd_height <= 1'b0;
        end else begin
            err_odd_width  <= load && up_tlast && (up_tuser || !col);
            err_odd_height <= load && up_tuser && (state == RUN) && row;
        end
    end
`endif

endmodule

// File: tb/tb_quad_lane_router.sv
// Self-checking bench for quad_lane_router: per-cycle scoreboard against a frame-position
// model plus literal per-lane delivery lists.
module tb_quad_lane_router;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] up_data = '0;
    logic       up_valid = 1'b0, up_tlast = 1'b0, up_tuser = 1'b0;
    logic       up_ready;
    logic [7:0] down_data_a, down_data_b, down_data_c, down_data_d;
    logic       down_valid_a, down_valid_b, down_valid_c, down_valid_d;
    logic       down_tlast_a, down_tlast_b, down_tlast_c, down_tlast_d;
    logic       down_tuser_a, down_tuser_b, down_tuser_c, down_tuser_d;
    logic       down_ready_a = 1'b1, down_ready_b = 1'b1, down_ready_c = 1'b1, down_ready_d = 1'b1;
`ifdef QUAD_LANE_ROUTER_ERR_EN
    logic       err_odd_width, err_odd_height;
`endif

    quad_lane_router #(.D_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
        .up_ready(up_ready),
        .down_data_a(down_data_a), .down_valid_a(down_valid_a), .down_tlast_a(down_tlast_a),
        .down_tuser_a(down_tuser_a), .down_ready_a(down_ready_a),
        .down_data_b(down_data_b), .down_valid_b(down_valid_b), .down_tlast_b(down_tlast_b),
        .down_tuser_b(down_tuser_b), .down_ready_b(down_ready_b),
        .down_data_c(down_data_c), .down_valid_c(down_valid_c), .down_tlast_c(down_tlast_c),
        .down_tuser_c(down_tuser_c), .down_ready_c(down_ready_c),
        .down_data_d(down_data_d), .down_valid_d(down_valid_d), .down_tlast_d(down_tlast_d),
        .down_tuser_d(down_tuser_d), .down_ready_d(down_ready_d)
`ifdef QUAD_LANE_ROUTER_ERR_EN
        , .err_odd_width(err_odd_width), .err_odd_height(err_odd_height)
`endif
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic [3:0] dv, dr, dl, du;
    logic [7:0] dd [4];
    assign dv = {down_valid_d, down_valid_c, down_valid_b, down_valid_a};
    assign dr = {down_ready_d, down_ready_c, down_ready_b, down_ready_a};
    assign dl = {down_tlast_d, down_tlast_c, down_tlast_b, down_tlast_a};
    assign du = {down_tuser_d, down_tuser_c, down_tuser_b, down_tuser_a};
    assign dd[0] = down_data_a;
    assign dd[1] = down_data_b;
    assign dd[2] = down_data_c;
    assign dd[3] = down_data_d;

    // Model: position in frame (row/col as integers), whether a frame start was seen,
    // and the one beat that should currently be presented downstream.
    int         m_row, m_col, m_lane;
    bit         m_sync, m_full, m_last, m_user, m_errw, m_errh;
    logic [7:0] m_data;

    function automatic int dest(input bit u, input int r, input int c);
        return u ? 0 : r * 2 + c;
    endfunction

    wire m_ready = !m_full || dr[m_lane];
    wire m_keep  = up_valid && m_ready && (m_sync || up_tuser);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_row <= 0; m_col <= 0; m_lane <= 0; m_sync <= 0; m_full <= 0;
            m_last <= 0; m_user <= 0; m_errw <= 0; m_errh <= 0; m_data <= '0;
        end else begin
            m_errw <= m_keep && up_tlast && (up_tuser || m_col == 0);
            m_errh <= m_keep && up_tuser && m_sync && m_row == 1;
            if (m_keep) begin
                m_full <= 1; m_sync <= 1;
                m_lane <= dest(up_tuser, m_row, m_col);
                m_data <= up_data; m_last <= up_tlast; m_user <= up_tuser;
                if (up_tuser) begin
                    m_row <= up_tlast ? 1 : 0;
                    m_col <= up_tlast ? 0 : 1;
                end else if (up_tlast) begin
                    m_col <= 0;
                    m_row <= 1 - m_row;
                end else begin
                    m_col <= 1 - m_col;
                end
            end else if (m_full && dr[m_lane]) begin
                m_full <= 0;
            end
        end
    end

    logic [7:0] lg [4][$];
    int ew_cnt = 0, eh_cnt = 0;

    always @(negedge clk) begin
        chk("up_ready", {31'd0, up_ready}, {31'd0, m_ready});
        for (int x = 0; x < 4; x++)
            chk($sformatf("valid_%0d", x), {31'd0, dv[x]}, {31'd0, (m_full && m_lane == x)});
        if (m_full) begin
            chk("data", {24'd0, dd[m_lane]}, {24'd0, m_data});
            chk("tlast", {31'd0, dl[m_lane]}, {31'd0, m_last});
            chk("tuser", {31'd0, du[m_lane]}, {31'd0, m_user});
        end
`ifdef QUAD_LANE_ROUTER_ERR_EN
        chk("err_odd_width", {31'd0, err_odd_width}, {31'd0, m_errw});
        chk("err_odd_height", {31'd0, err_odd_height}, {31'd0, m_errh});
        if (err_odd_width) ew_cnt++;
        if (err_odd_height) eh_cnt++;
`endif
        for (int x = 0; x < 4; x++)
            if (dv[x] && dr[x]) lg[x].push_back(dd[x]);
    end

    task automatic beat(input logic [7:0] d, input bit l, input bit u);
        int n = 0;
        bit ok = 0;
        up_data = d; up_tlast = l; up_tuser = u; up_valid = 1;
        do begin
            @(negedge clk); ok = up_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 100);
        if (!ok) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL beat_timeout data=%0h actual=not accepted required=accepted", d);
        end
        up_valid = 0; up_tlast = 0; up_tuser = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr_logs();
        for (int x = 0; x < 4; x++) lg[x].delete();
        ew_cnt = 0; eh_cnt = 0;
    endtask

    task automatic chk_log(input string nm, input int ln, input int n,
                           input logic [7:0] e0, input logic [7:0] e1);
        chk({nm, "_count"}, lg[ln].size(), n);
        if (n > 0 && lg[ln].size() > 0) chk({nm, "_0"}, {24'd0, lg[ln][0]}, {24'd0, e0});
        if (n > 1 && lg[ln].size() > 1) chk({nm, "_1"}, {24'd0, lg[ln][1]}, {24'd0, e1});
    endtask

    int c0;

    initial begin
        // Reset state
        idle(2);
        @(negedge clk);
        chk("rst_valid", {28'd0, dv}, 32'd0);
        chk("rst_data_a", {24'd0, down_data_a}, 32'd0);
        chk("rst_up_ready", {31'd0, up_ready}, 32'd1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("first_up_ready", {31'd0, up_ready}, 32'd1);
        @(posedge clk); #1;

        // Beats before frame start are dropped
        clr_logs();
        beat(8'hAA, 0, 0);
        beat(8'hBB, 0, 0);
        beat(8'h01, 0, 1);
        @(negedge clk);
        chk("sync_lat_valid_a", {31'd0, down_valid_a}, 32'd1);
        chk("sync_lat_data_a", {24'd0, down_data_a}, 32'h01);
        idle(2);
        chk_log("sync_a", 0, 1, 8'h01, 8'h00);
        chk_log("sync_b", 1, 0, 8'h00, 8'h00);

        // 4x2 frame at full throughput
        clr_logs();
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            beat(8'h10 + 8'(i), (i == 3 || i == 7), (i == 0));
        chk("frame_cycles", cyc - c0, 8);
        idle(2);
        chk_log("frame_a", 0, 2, 8'h10, 8'h12);
        chk_log("frame_b", 1, 2, 8'h11, 8'h13);
        chk_log("frame_c", 2, 2, 8'h14, 8'h16);
        chk_log("frame_d", 3, 2, 8'h15, 8'h17);

        // Backpressure on lane b
        clr_logs();
        beat(8'h10, 0, 1);
        down_ready_b = 0;
        beat(8'h11, 0, 0);
        up_data = 8'h12; up_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data_b", {24'd0, down_data_b}, 32'h11);
            chk("stall_up_ready", {31'd0, up_ready}, 32'd0);
            @(posedge clk); #1;
        end
        down_ready_b = 1;
        beat(8'h12, 0, 0);
        beat(8'h13, 1, 0);
        idle(2);
        chk_log("stall_a", 0, 2, 8'h10, 8'h12);
        chk_log("stall_b", 1, 2, 8'h11, 8'h13);

        // Mid-line resync at row 1, col 1
        clr_logs();
        beat(8'h20, 0, 0);
        beat(8'h55, 0, 1);
        beat(8'h56, 0, 0);
        idle(2);
        chk_log("resync_c", 2, 1, 8'h20, 8'h00);
        chk_log("resync_a", 0, 1, 8'h55, 8'h00);
        chk_log("resync_b", 1, 1, 8'h56, 8'h00);
`ifdef QUAD_LANE_ROUTER_ERR_EN
        chk("err_height_pulses", eh_cnt, 1);
`endif

        // Odd line length
        clr_logs();
        beat(8'h60, 0, 1);
        beat(8'h61, 0, 0);
        beat(8'h62, 1, 0);
        beat(8'h63, 0, 0);
        idle(2);
        chk_log("odd_a", 0, 2, 8'h60, 8'h62);
        chk_log("odd_b", 1, 1, 8'h61, 8'h00);
        chk_log("odd_c", 2, 1, 8'h63, 8'h00);
`ifdef QUAD_LANE_ROUTER_ERR_EN
        chk("err_width_pulses", ew_cnt, 1);
`endif

        // Reset while lane c holds a beat
        beat(8'h70, 0, 1);
        beat(8'h71, 1, 0);
        down_ready_c = 0;
        beat(8'h72, 0, 0);
        #1 rst = 0;
        #1 chk("async_rst_valid_c", {31'd0, down_valid_c}, 32'd0);
        @(posedge clk); #1 rst = 1; down_ready_c = 1;
        clr_logs();
        beat(8'h80, 0, 0);
        beat(8'h81, 0, 1);
        idle(2);
        chk_log("post_rst_a", 0, 1, 8'h81, 8'h00);
        chk_log("post_rst_c", 2, 0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/quad_lane_router.md
QUAD_LANE_ROUTER -- requirements
Module: quad_lane_router

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, pixel data width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports up_data/up_valid/up_tlast/up_tuser  input  D_WIDTH/1/1/1  upstream pixel stream; tlast = end of line, tuser = start of frame.
REQ-005 SHALL have port up_ready  output  1  upstream acceptance.
REQ-006 SHALL have ports down_data_x/down_valid_x/down_tlast_x/down_tuser_x  output  D_WIDTH/1/1/1  for lanes x = a,b,c,d.
REQ-007 SHALL have ports down_ready_x  input  1  per-lane acceptance, x = a,b,c,d.

Function
REQ-008 SHALL accept a beat on cycle where up_valid && up_ready; SHALL transfer lane x on down_valid_x && down_ready_x.
REQ-009 SHALL route by (row parity, column parity): even/even -> a, even/odd -> b, odd/even -> c, odd/odd -> d.
REQ-010 SHALL forward data, tlast, tuser unmodified to the selected lane only.
REQ-011 SHALL use one output register (data, tlast, tuser, 2-bit lane select, full flag); latency exactly 1 cycle from acceptance to down_valid_x.
REQ-012 SHALL assert at most one down_valid_x per cycle, equal to full && (sel == x).
REQ-013 SHALL drive up_ready = !full || (down_ready of selected lane), allowing one beat per cycle at full throughput.
REQ-014 SHALL hold output register contents stable while down_valid_x && !down_ready_x.
REQ-015 SHALL implement FSM states SYNC and RUN.
REQ-016 In SYNC: up_ready = 1, beats with tuser = 0 discarded, no lane valid raised.
REQ-017 SYNC -> RUN on accepted beat with tuser = 1; that beat SHALL route to lane a with row = col = 0.
REQ-018 In RUN, accepted beat with tuser = 1 SHALL resync: route to a, then col = 1, row = 0.
REQ-019 In RUN, accepted beat with tlast = 1 SHALL set col = 0 and toggle row after routing.
REQ-020 In RUN, accepted beat with tlast = 0 and tuser = 0 SHALL toggle col.
REQ-021 Beat with tuser = 1 and tlast = 1 SHALL route to a, then col = 0, row = 1.
REQ-022 Row/col counters SHALL be 1 bit each, wrapping naturally.
REQ-023 FSM SHALL never return to SYNC except via reset.

Reset
REQ-024 On rst = 0, SHALL immediately clear full, all down_valid_x, row, col, down_data_x/tlast/tuser to 0 and enter SYNC.
REQ-025 Reset asserted mid-frame SHALL drop any held beat; first post-reset routed beat SHALL be a tuser beat.
REQ-026 After release, up_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 With macro QUAD_LANE_ROUTER_ERR_EN defined, SHALL add outputs err_odd_width and err_odd_height (1 bit each, reset 0).
REQ-028 err_odd_width SHALL pulse 1 cycle after accepting a tlast beat with col = 0 (odd line length).
REQ-029 err_odd_height SHALL pulse 1 cycle after accepting a tuser beat in RUN with row = 1 (odd line count).
REQ-030 Without QUAD_LANE_ROUTER_ERR_EN, these ports and logic SHALL be absent; routing unchanged.

Verification
REQ-031 Reset, frame 4x2 pixels 0x10..0x17, tuser on first, tlast on 4th/8th, all ready = 1 -> a gets 10,12; b 11,13; c 14,16; d 15,17; one beat per cycle.
REQ-032 Beats 0xAA,0xBB without tuser, then 0x01 with tuser -> AA, BB dropped, up_ready = 1, 0x01 on lane a 1 cycle later.
REQ-033 down_ready_b = 0 for 5 cycles while b beat 0x11 held -> down_data_b stable 0x11, up_ready = 0, no beats lost, resumes on release.
REQ-034 Mid-line tuser beat 0x55 at row 1, col 1 -> 0x55 on lane a, next beat on b; with ERR_EN err_odd_height pulses once.
REQ-035 Line of 3 pixels (tlast on 3rd) with ERR_EN -> err_odd_width = 1 for one cycle; next line starts on lane c.
REQ-036 rst = 0 while lane c holds valid beat -> down_valid_c = 0 same cycle, FSM SYNC, next tuser beat routed to a.
